mdu_unit: RTL

Multiply/divide unit for the E stage of the five-stage MIPS pipeline. It accepts mult, multu, div and divu operations, and models multi-cycle latency with a busy countdown. It owns the HI/LO register pair and serves mthi and mtlo writes. Its `busy` output feeds the D-stage stall logic, which holds any HI/LO-touching instruction in D while an operation is in flight.

---
 rtl/mdu_unit.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/mdu_unit.sv
// mdu_unit: MIPS E-stage multiply/divide unit owning the HI/LO register pair.
// Latency: mult/multu complete MULT_CYCLES edges after the start edge, div/divu after DIV_CYCLES; mthi/mtlo take 1 edge.
// Backpressure: none accepted; o_busy is raised for the whole run so D-stage stall logic holds HI/LO users.
//
// Ports:
//   i_clk        rising-edge clock
//   i_reset      asynchronous reset, active low
//   i_md_start   E-stage holds mult/multu/div/divu (sampled at posedge)
//   i_md_op      00 mult, 01 multu, 10 div, 11 divu
//   i_md_a       rs value: multiplicand / dividend / mthi-mtlo source
//   i_md_b       rt value: multiplier / divisor
//   i_md_mthi    write i_md_a to HI (IDLE and no start only)
//   i_md_mtlo    write i_md_a to LO (IDLE and no start only)
//   o_busy       operation in flight (registered)
//   o_hi, o_lo   architectural HI/LO registers
module mdu_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_md_start,
   input  logic [1:0]  i_md_op,
   input  logic [31:0] i_md_a,
   input  logic [31:0] i_md_b,
   input  logic        i_md_mthi,
   input  logic        i_md_mtlo,
   output logic        o_busy,
   output logic [31:0] o_hi,
   output logic [31:0] o_lo
);

   // Counter holds the larger latency; never narrower than 4 bits.
   localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW_RAW  = $clog2(MAX_CYC + 1);
   localparam int CW      = (CW_RAW < 4) ? 4 : CW_RAW;
   localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES);
   localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic          r_busy;
   logic          w_ld_pend;
   logic          w_commit;
   logic          w_mt_en;

   logic [31:0]   r_hi;
   logic [31:0]   r_lo;
   logic [31:0]   r_hi_p;
   logic [31:0]   r_lo_p;
   logic          r_sup;

   // ------------------------------------------------------------------
   // Arithmetic, evaluated on the start cycle only
   // ------------------------------------------------------------------
   logic          w_is_div;
   logic          w_is_uns;
   logic [63:0]   w_a_sx;
   logic [63:0]   w_b_sx;
   logic [63:0]   w_prod_s;
   logic [63:0]   w_prod_u;
   logic          w_a_neg;
   logic          w_b_neg;
   logic [31:0]   w_a_mag;
   logic [31:0]   w_b_mag;
   logic          w_div_zero;
   logic [31:0]   w_den;
   logic [31:0]   w_q_mag;
   logic [31:0]   w_r_mag;
   logic [31:0]   w_quo;
   logic [31:0]   w_rem;
   logic [31:0]   w_hi_res;
   logic [31:0]   w_lo_res;

   assign w_is_div = i_md_op[1];
   assign w_is_uns = i_md_op[0];

   // Low 64 bits of a 64x64 product of sign-extended operands is the signed 32x32 product.
   assign w_a_sx   = {{32{i_md_a[31]}}, i_md_a};
   assign w_b_sx   = {{32{i_md_b[31]}}, i_md_b};
   assign w_prod_s = w_a_sx * w_b_sx;
   assign w_prod_u = {32'd0, i_md_a} * {32'd0, i_md_b};

   // Signed divide via magnitudes: quotient sign is the XOR of operand signs,
   // remainder takes the dividend's sign. 0x80000000 / -1 falls out as
   // quotient 0x80000000 (magnitude wraps back onto itself), remainder 0.
   assign w_a_neg    = ~w_is_uns & i_md_a[31];
   assign w_b_neg    = ~w_is_uns & i_md_b[31];
   assign w_a_mag    = w_a_neg ? (32'd0 - i_md_a) : i_md_a;
   assign w_b_mag    = w_b_neg ? (32'd0 - i_md_b) : i_md_b;
   assign w_div_zero = (i_md_b == 32'd0);
   // Divide-by-zero result is discarded; a dummy divisor keeps the datapath defined.
   assign w_den      = w_div_zero ? 32'd1 : w_b_mag;
   assign w_q_mag    = w_a_mag / w_den;
   assign w_r_mag    = w_a_mag % w_den;
   assign w_quo      = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
   assign w_rem      = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

   always_comb begin
      w_hi_res = w_prod_s[63:32];
      w_lo_res = w_prod_s[31:0];
      if (w_is_div) begin
         w_hi_res = w_rem;
         w_lo_res = w_quo;
      end else if (w_is_uns) begin
         w_hi_res = w_prod_u[63:32];
         w_lo_res = w_prod_u[31:0];
      end
   end

   // ------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_busy  <= (w_state_nxt == ST_RUN);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_ld_pend   = 1'b0;
      w_commit    = 1'b0;
      w_mt_en     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_md_start) begin
               w_ld_pend   = 1'b1;
               w_cnt_nxt   = w_is_div ? DIV_LD : MULT_LD;
               w_state_nxt = ST_RUN;
            end else begin
               w_mt_en = 1'b1;
            end
         end
         ST_RUN: begin
            // A start seen here is dropped: stall logic never issues one.
            w_cnt_nxt = r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
               w_commit    = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Pending result and suppress flag
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_hi_p <= '0;
         r_lo_p <= '0;
         r_sup  <= 1'b0;
      end else if (w_ld_pend) begin
         r_hi_p <= w_hi_res;
         r_lo_p <= w_lo_res;
         r_sup  <= w_is_div & w_div_zero;
      end
   end

   // ------------------------------------------------------------------
   // Architectural HI/LO: commit (RUN only) and mthi/mtlo (IDLE only) never overlap.
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_hi <= '0;
         r_lo <= '0;
      end else if (w_commit) begin
         if (!r_sup) begin
            r_hi <= r_hi_p;
            r_lo <= r_lo_p;
         end
      end else if (w_mt_en) begin
         if (i_md_mthi) r_hi <= i_md_a;
         if (i_md_mtlo) r_lo <= i_md_a;
      end
   end

   assign o_busy = r_busy;
   assign o_hi   = r_hi;
   assign o_lo   = r_lo;

endmodule
